// File: rtl/core_cmd_sequencer_pkg.sv
// core_manage_types: shared constants and types for the core manager and its
// command sequencer.
//   NUM_CPUS / CORE_W       : number of managed cores and the core-index width
//   WADDR_MAN               : register address of the core manager
//   HALTCn / NHALTCn        : command codes that halt / release core n
//   HALT_BIT                : bit of the readback word that holds the halt state
//   seq_state_e             : sequencer FSM states
//   cmd_code(), core_valid(): command-code lookup and core-range check
package core_manage_types;

  localparam int unsigned NUM_CPUS = 3;
  localparam int unsigned CORE_W   = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;

  localparam logic [31:0] WADDR_MAN = 32'h0000_0040;

  localparam logic [31:0] HALTC0  = 32'h0000_0011;
  localparam logic [31:0] HALTC1  = 32'h0000_0012;
  localparam logic [31:0] HALTC2  = 32'h0000_0013;
  localparam logic [31:0] NHALTC0 = 32'h0000_0021;
  localparam logic [31:0] NHALTC1 = 32'h0000_0022;
  localparam logic [31:0] NHALTC2 = 32'h0000_0023;

  localparam int unsigned HALT_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_READ   = 3'd3,
    ST_CHECK  = 3'd4
  } seq_state_e;

  // Manager command word for a halt (halt=1) or release (halt=0) of one core.
  function automatic logic [31:0] cmd_code(input logic [CORE_W-1:0] core, input logic halt);
    logic [31:0] code;
    case (core)
      CORE_W'(0): code = halt ? HALTC0 : NHALTC0;
      CORE_W'(1): code = halt ? HALTC1 : NHALTC1;
      CORE_W'(2): code = halt ? HALTC2 : NHALTC2;
      default:    code = 32'h0000_0000;
    endcase
    return code;
  endfunction

  // True when the index names a core that actually exists.
  function automatic logic core_valid(input logic [CORE_W-1:0] core);
    return (32'(core) < NUM_CPUS);
  endfunction

endpackage

// File: rtl/core_cmd_sequencer_if.sv
// core_cmd_sequencer_if: command-queue handshake plus write/readback bus of the
// core manager.
//   cmd_valid/cmd_ready/cmd_core/cmd_halt : command offer into the queue
//   w_valid/awvalid/waddr/wdata           : write strobe to the manager
//   arvalid/raddr, rvalid/rdata           : readback request and response
// master = sequencer side, slave = command source + manager side.
interface core_cmd_sequencer_if;

  logic                                 cmd_valid;
  logic                                 cmd_ready;
  logic [core_manage_types::CORE_W-1:0] cmd_core;
  logic                                 cmd_halt;
  logic                                 w_valid;
  logic                                 awvalid;
  logic [31:0]                          waddr;
  logic [31:0]                          wdata;
  logic                                 arvalid;
  logic [31:0]                          raddr;
  logic                                 rvalid;
  logic [31:0]                          rdata;

  modport master (
    input  cmd_valid, cmd_core, cmd_halt, rvalid, rdata,
    output cmd_ready, w_valid, awvalid, waddr, wdata, arvalid, raddr
  );

  modport slave (
    output cmd_valid, cmd_core, cmd_halt, rvalid, rdata,
    input  cmd_ready, w_valid, awvalid, waddr, wdata, arvalid, raddr
  );

endinterface

// File: rtl/core_cmd_sequencer_fifo.sv
// cmd_fifo: small synchronous FIFO holding pending commands.
//   clk, rst (async, active-high)
//   i_push/i_din : write side; a push while full is taken if a pop happens
//                  in the same cycle
//   i_pop/o_dout : read side; o_dout shows the head entry
//   o_full/o_empty : occupancy flags
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module cmd_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == (AW+1)'(0));
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/core_cmd_sequencer.sv
// core_cmd_sequencer: queues halt/release commands for individual cores, writes
// each to the core manager, reads the core's halt state back and retries until
// it matches or the retry budget runs out.
//   clk, rst (async, active-high), pwr (power-good)
//   bus      : command handshake, manager write strobe and readback (master)
//   busy     : FSM not idle
//   done     : one-cycle pulse per confirmed command
//   err      : sticky failure flag, cleared only by rst
//   err_core : core of the most recent failure
module core_cmd_sequencer
  import core_manage_types::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwr,
  core_cmd_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [CORE_W-1:0]     err_core
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  seq_state_e         r_state, w_state_nxt;
  logic [CORE_W-1:0]  r_hold_core, w_hold_core_nxt;
  logic               r_hold_halt, w_hold_halt_nxt;
  logic [RETRY_W-1:0] r_retry, w_retry_nxt, w_retry_inc;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
  logic               r_rd_halt, w_rd_halt_nxt;
  logic               w_pop, w_done_nxt, w_err_set;

  logic [CORE_W:0]    w_head;
  logic               w_full, w_empty;

  logic               r_w_valid, r_awvalid, r_arvalid;
  logic [31:0]        r_waddr, r_wdata, r_raddr;
  logic               r_busy, r_done, r_err;
  logic [CORE_W-1:0]  r_err_core;

  cmd_fifo #(
    .WIDTH (CORE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (bus.cmd_valid && bus.cmd_ready),
    .i_din   ({bus.cmd_core, bus.cmd_halt}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_retry_inc = r_retry + RETRY_W'(1);

  // Next-state, command holding and retry/timeout bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_hold_core_nxt = r_hold_core;
    w_hold_halt_nxt = r_hold_halt;
    w_retry_nxt     = r_retry;
    w_tmo_nxt       = r_tmo;
    w_rd_halt_nxt   = r_rd_halt;
    w_pop           = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_set       = 1'b0;
    if (!pwr && (r_state != ST_IDLE)) begin
      // Power loss abandons the in-flight command silently.
      w_state_nxt = ST_IDLE;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty && pwr) begin
            w_pop           = 1'b1;
            w_hold_core_nxt = w_head[CORE_W:1];
            w_hold_halt_nxt = w_head[0];
            w_retry_nxt     = '0;
            // A nonexistent core fails on the spot without touching the bus.
            if (core_valid(w_head[CORE_W:1])) begin
              w_state_nxt = ST_WRITE;
            end else begin
              w_err_set   = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WRITE: begin
          w_state_nxt = ST_SETTLE;
        end
        ST_SETTLE: begin
          w_state_nxt = ST_READ;
          w_tmo_nxt   = '0;
        end
        ST_READ: begin
          if (bus.rvalid) begin
            w_state_nxt   = ST_CHECK;
            w_rd_halt_nxt = bus.rdata[HALT_BIT];
          end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
            w_err_set   = 1'b1;
            w_retry_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_tmo_nxt = r_tmo + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          if (r_rd_halt == r_hold_halt) begin
            w_done_nxt  = 1'b1;
            w_retry_nxt = '0;
            w_state_nxt = ST_IDLE;
          end else if (w_retry_inc < RETRY_W'(MAX_RETRY)) begin
            w_retry_nxt = w_retry_inc;
            w_state_nxt = ST_WRITE;
          end else begin
            w_err_set   = 1'b1;
            w_retry_nxt = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_hold_core <= '0;
      r_hold_halt <= 1'b0;
      r_retry     <= '0;
      r_tmo       <= '0;
      r_rd_halt   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_core <= w_hold_core_nxt;
      r_hold_halt <= w_hold_halt_nxt;
      r_retry     <= w_retry_nxt;
      r_tmo       <= w_tmo_nxt;
      r_rd_halt   <= w_rd_halt_nxt;
    end
  end

  // Outputs are registered from the next state so each strobe is high exactly
  // while the FSM sits in the matching state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_valid  <= 1'b0;
      r_awvalid  <= 1'b0;
      r_arvalid  <= 1'b0;
      r_waddr    <= 32'h0000_0000;
      r_wdata    <= 32'h0000_0000;
      r_raddr    <= 32'h0000_0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_core <= '0;
    end else begin
      r_w_valid <= (w_state_nxt == ST_WRITE);
      r_awvalid <= (w_state_nxt == ST_WRITE);
      r_arvalid <= (w_state_nxt == ST_READ);
      r_waddr   <= (w_state_nxt == ST_WRITE) ? WADDR_MAN : 32'h0000_0000;
      r_wdata   <= (w_state_nxt == ST_WRITE) ? cmd_code(w_hold_core_nxt, w_hold_halt_nxt)
                                             : 32'h0000_0000;
      r_raddr   <= (w_state_nxt == ST_READ) ? 32'(w_hold_core_nxt) : 32'h0000_0000;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_core <= w_hold_core_nxt;
      end else begin
        r_err      <= r_err;
        r_err_core <= r_err_core;
      end
    end
  end

  assign bus.cmd_ready = !w_full;
  assign bus.w_valid   = r_w_valid;
  assign bus.awvalid   = r_awvalid;
  assign bus.waddr     = r_waddr;
  assign bus.wdata     = r_wdata;
  assign bus.arvalid   = r_arvalid;
  assign bus.raddr     = r_raddr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;
  assign err_core      = r_err_core;

endmodule

// File: tb/tb_core_cmd_sequencer.sv
module tb_core_cmd_sequencer;
  import core_manage_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwr = 1'b1;
  logic busy, done, err;
  logic [CORE_W-1:0] err_core;

  core_cmd_sequencer_if bus();

  core_cmd_sequencer #(.FIFO_DEPTH(4), .MAX_RETRY(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pwr(pwr), .bus(bus),
    .busy(busy), .done(done), .err(err), .err_core(err_core)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference command codes, indexed by core and halt bit.
  function automatic logic [31:0] exp_code(input int c, input logic h);
    logic [31:0] t [3][2];
    t[0][0] = NHALTC0; t[0][1] = HALTC0;
    t[1][0] = NHALTC1; t[1][1] = HALTC1;
    t[2][0] = NHALTC2; t[2][1] = HALTC2;
    if (c >= 0 && c < 3) return t[c][h];
    return 32'hDEAD_BEEF;
  endfunction

  // Behavioural core manager: halt state per core, optional ignored halts,
  // readback answered after mgr_lat cycles of arvalid.
  logic [2:0] halted      = 3'b010;
  logic [2:0] mgr_ignore  = 3'b000;
  bit         mgr_respond = 1'b1;
  int         mgr_lat     = 0;
  int         rd_wait     = 0;

  always @(posedge clk) begin
    rd_wait <= bus.arvalid ? rd_wait + 1 : 0;
    if (bus.w_valid && bus.awvalid && bus.waddr == WADDR_MAN) begin
      for (int c = 0; c < 3; c++) begin
        if (bus.wdata == exp_code(c, 1'b1) && !mgr_ignore[c]) halted[c] <= 1'b1;
        if (bus.wdata == exp_code(c, 1'b0)) halted[c] <= 1'b0;
      end
    end
  end

  assign bus.rvalid = bus.arvalid && mgr_respond && (rd_wait >= mgr_lat);
  assign bus.rdata  = (bus.raddr < 32'd3) ? (32'(halted[bus.raddr[1:0]]) << HALT_BIT) : 32'd0;

  // Bus monitor: write log, event counters, protocol violations.
  int          n_wr = 0, n_rd = 0, n_done = 0, n_viol = 0;
  logic [31:0] wr_log [$];
  logic        prev_done = 1'b0;

  always @(negedge clk) begin
    if (bus.w_valid) begin
      n_wr <= n_wr + 1;
      wr_log.push_back(bus.wdata);
    end
    if (bus.arvalid) n_rd <= n_rd + 1;
    if (done) n_done <= n_done + 1;
    if ((bus.w_valid && bus.arvalid) || (bus.w_valid !== bus.awvalid) || (done && prev_done))
      n_viol <= n_viol + 1;
    prev_done <= done;
  end

  task automatic do_reset();
    rst = 1'b1;
    pwr = 1'b1;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Offer one command; ready is sampled mid-cycle, acceptance at the next edge.
  task automatic push(input logic [1:0] c, input logic h, output bit ok);
    int budget = 200;
    bit rdy;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_core  = c;
    bus.cmd_halt  = h;
    while (!ok && budget > 0) begin
      rdy = bus.cmd_ready;
      @(posedge clk);
      #1;
      if (rdy) ok = 1'b1;
      budget--;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({bus.w_valid, bus.awvalid, bus.arvalid, done, err, busy, bus.cmd_ready} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000001",
               {bus.w_valid, bus.awvalid, bus.arvalid, done, err, busy, bus.cmd_ready});
    end
    n_tests++;
    if (bus.waddr !== 32'd0 || bus.wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_wbus: got waddr=%h wdata=%h expected 0", bus.waddr, bus.wdata);
    end
    n_tests++;
    if (bus.raddr !== 32'd0 || err_core !== '0) begin
      n_fail++;
      $display("FAIL reset_raddr: got raddr=%h err_core=%0d expected 0", bus.raddr, err_core);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    mgr_lat = 0;
    push(2'd1, 1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic_push: got not accepted expected accepted"); end
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus.w_valid !== 1'b1 || bus.awvalid !== 1'b1 || bus.waddr !== WADDR_MAN) begin
      n_fail++;
      $display("FAIL basic_write: got w_valid=%b awvalid=%b waddr=%h expected 1 1 %h",
               bus.w_valid, bus.awvalid, bus.waddr, WADDR_MAN);
    end
    n_tests++;
    if (bus.wdata !== exp_code(1, 1'b0)) begin
      n_fail++;
      $display("FAIL basic_wdata: got %h expected %h", bus.wdata, exp_code(1, 1'b0));
    end
    @(negedge clk);
    n_tests++;
    if (bus.w_valid !== 1'b0 || bus.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_settle: got w_valid=%b arvalid=%b expected 0 0", bus.w_valid, bus.arvalid);
    end
    @(negedge clk);
    n_tests++;
    if (bus.arvalid !== 1'b1 || bus.raddr !== 32'd1) begin
      n_fail++;
      $display("FAIL basic_read: got arvalid=%b raddr=%h expected 1 1", bus.arvalid, bus.raddr);
    end
    repeat (2) @(negedge clk);
    n_tests++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_after: got done=%b busy=%b err=%b expected 0 0 0", done, busy, err);
    end
  endtask

  task automatic test_retry_err();
    bit ok;
    int w0, d0, k;
    do_reset();
    mgr_lat = $urandom_range(0, 2);
    mgr_ignore = 3'b100;
    w0 = n_wr;
    d0 = n_done;
    push(2'd2, 1'b1, ok);
    k = 0;
    while (!err && k < 100) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || err_core !== 2'd2) begin
      n_fail++;
      $display("FAIL retry_err: got err=%b err_core=%0d expected 1 2", err, err_core);
    end
    n_tests++;
    if (n_wr - w0 != 3) begin
      n_fail++;
      $display("FAIL retry_writes: got %0d expected 3", n_wr - w0);
    end
    n_tests++;
    if (n_done != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL retry_nodone: got dones=%0d busy=%b expected 0 0", n_done - d0, busy);
    end
    mgr_ignore = 3'b000;
  endtask

  task automatic test_back_to_back();
    logic [1:0] c [6];
    logic       h [6];
    bit ok;
    int w0, d0, k, acc;
    do_reset();
    mgr_lat = $urandom_range(1, 3);
    for (int i = 0; i < 6; i++) begin
      c[i] = 2'($urandom_range(0, 2));
      h[i] = 1'($urandom_range(0, 1));
    end
    w0 = wr_log.size();
    d0 = n_done;
    push(c[0], h[0], ok);
    k = 0;
    while (!busy && k < 10) begin @(negedge clk); k++; end
    acc = 0;
    for (int i = 1; i <= 4; i++) begin
      push(c[i], h[i], ok);
      if (ok) acc++;
    end
    n_tests++;
    if (acc != 4 || bus.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_full: got accepted=%0d cmd_ready=%b expected 4 0", acc, bus.cmd_ready);
    end
    push(c[5], h[5], ok);
    k = 0;
    while ((n_done - d0) < 6 && k < 400) begin @(negedge clk); k++; end
    @(negedge clk);
    n_tests++;
    if (n_done - d0 != 6 || wr_log.size() - w0 != 6) begin
      n_fail++;
      $display("FAIL b2b_count: got dones=%0d writes=%0d expected 6 6", n_done - d0, wr_log.size() - w0);
    end
    for (int i = 0; i < 6; i++) begin
      if (wr_log.size() > w0 + i) begin
        n_tests++;
        if (wr_log[w0 + i] !== exp_code(int'(c[i]), h[i])) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: got %h expected %h", i, wr_log[w0 + i], exp_code(int'(c[i]), h[i]));
        end
      end
    end
  endtask

  task automatic test_pwr_drop();
    bit ok;
    int w0, d0, wp, k;
    do_reset();
    mgr_lat = 3;
    w0 = n_wr;
    d0 = n_done;
    push(2'd0, 1'b1, ok);
    push(2'd1, 1'b1, ok);
    k = 0;
    while (!bus.arvalid && k < 20) begin @(negedge clk); k++; end
    pwr = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.arvalid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pwr_drop: got arvalid=%b busy=%b err=%b expected 0 0 0", bus.arvalid, busy, err);
    end
    repeat (4) @(negedge clk);
    wp = n_wr;
    repeat (3) @(negedge clk);
    n_tests++;
    if (n_wr != wp || busy !== 1'b0 || n_done != d0) begin
      n_fail++;
      $display("FAIL pwr_idle: got new_writes=%0d busy=%b dones=%0d expected 0 0 0", n_wr - wp, busy, n_done - d0);
    end
    pwr = 1'b1;
    k = 0;
    while ((n_done - d0) < 1 && k < 60) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    n_tests++;
    if (n_done - d0 != 1 || n_wr - w0 != 2 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL pwr_resume: got dones=%0d writes=%0d err=%b expected 1 2 0", n_done - d0, n_wr - w0, err);
    end
    n_tests++;
    if (wr_log[wr_log.size() - 1] !== exp_code(1, 1'b1)) begin
      n_fail++;
      $display("FAIL pwr_resume_cmd: got %h expected %h", wr_log[wr_log.size() - 1], exp_code(1, 1'b1));
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int k, cnt;
    logic err_early;
    do_reset();
    mgr_respond = 1'b0;
    push(2'd0, 1'b1, ok);
    k = 0;
    while (!bus.arvalid && k < 20) begin @(negedge clk); k++; end
    cnt = bus.arvalid ? 1 : 0;
    err_early = err;
    k = 0;
    while (bus.arvalid && k < 40) begin
      @(negedge clk);
      if (bus.arvalid) begin cnt++; err_early = err_early | err; end
      k++;
    end
    n_tests++;
    if (cnt != 15) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 15", cnt); end
    n_tests++;
    if (err !== 1'b1 || err_core !== 2'd0 || err_early !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err: got err=%b err_core=%0d early=%b expected 1 0 0", err, err_core, err_early);
    end
    mgr_respond = 1'b1;
  endtask

  task automatic test_invalid_core();
    bit ok;
    int w0, r0, k;
    do_reset();
    w0 = n_wr;
    r0 = n_rd;
    push(2'd3, 1'b1, ok);
    k = 0;
    while (!err && k < 10) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    n_tests++;
    if (err !== 1'b1 || err_core !== 2'd3) begin
      n_fail++;
      $display("FAIL badcore_err: got err=%b err_core=%0d expected 1 3", err, err_core);
    end
    n_tests++;
    if (n_wr != w0 || n_rd != r0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL badcore_bus: got writes=%0d reads=%0d busy=%b expected 0 0 0", n_wr - w0, n_rd - r0, busy);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    int k, w1, r1;
    do_reset();
    mgr_lat = 1;
    push(2'd2, 1'b0, ok);
    push(2'd0, 1'b0, ok);
    k = 0;
    while (!bus.w_valid && k < 20) begin @(negedge clk); k++; end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.w_valid, bus.awvalid, bus.arvalid, done, err, busy, bus.cmd_ready} !== 7'b0000001) begin
      n_fail++;
      $display("FAIL rstmid_flags: got %b expected 0000001",
               {bus.w_valid, bus.awvalid, bus.arvalid, done, err, busy, bus.cmd_ready});
    end
    n_tests++;
    if (bus.waddr !== 32'd0 || bus.wdata !== 32'd0 || bus.raddr !== 32'd0 || err_core !== '0) begin
      n_fail++;
      $display("FAIL rstmid_bus: got waddr=%h wdata=%h raddr=%h err_core=%0d expected 0",
               bus.waddr, bus.wdata, bus.raddr, err_core);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    w1 = n_wr;
    r1 = n_rd;
    repeat (8) @(negedge clk);
    n_tests++;
    if (n_wr != w1 || n_rd != r1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got writes=%0d reads=%0d busy=%b expected 0 0 0", n_wr - w1, n_rd - r1, busy);
    end
  endtask

  task automatic test_invariants();
    n_tests++;
    if (n_viol != 0) begin n_fail++; $display("FAIL strobe_rules: got %0d violations expected 0", n_viol); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_core  = 2'd0;
    bus.cmd_halt  = 1'b0;
    test_reset();
    test_basic();
    test_retry_err();
    test_back_to_back();
    test_pwr_drop();
    test_timeout();
    test_invalid_core();
    test_reset_mid_write();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_cmd_sequencer.md
CORE_CMD_SEQUENCER -- requirements
Module: core_cmd_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command queue entries (power of 2).
REQ-002 SHALL have parameter MAX_RETRY, default 3: write/readback attempts before error.
REQ-003 SHALL have parameter TIMEOUT, default 15: cycles allowed for rvalid per read.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port pwr  in  1  power-good; same signal that feeds the core manager.
REQ-007 SHALL have port cmd_valid  in  1  command offered.
REQ-008 SHALL have port cmd_ready  out  1  queue not full.
REQ-009 SHALL have port cmd_core  in  $clog2(NUM_CPUS)  target core.
REQ-010 SHALL have port cmd_halt  in  1  1 = halt, 0 = release.
REQ-011 SHALL have ports w_valid and awvalid  out  1 each  write strobe to the core manager.
REQ-012 SHALL have ports waddr and wdata  out  32 each  write address and command code.
REQ-013 SHALL have ports arvalid  out  1  and raddr  out  32  readback request.
REQ-014 SHALL have ports rvalid  in  1  and rdata  in  32  readback response (combinational in the same cycle).
REQ-015 SHALL have port busy  out  1  high when the FSM is not IDLE.
REQ-016 SHALL have port done  out  1  one-cycle pulse when a command is confirmed.
REQ-017 SHALL have ports err  out  1  (sticky) and err_core  out  $clog2(NUM_CPUS)  core that failed.

Function
REQ-018 Queue SHALL accept {cmd_core, cmd_halt} when cmd_valid && cmd_ready; cmd_ready = !full.
REQ-019 Simultaneous push and pop SHALL be allowed when full; occupancy stays unchanged and the accepted entry is kept.
REQ-020 Read/write pointers SHALL wrap modulo FIFO_DEPTH; the count register SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-021 FSM states SHALL be IDLE, WRITE, SETTLE, READ, CHECK.
REQ-022 IDLE SHALL go to WRITE when the queue is non-empty and pwr=1; the head entry is popped into a holding register.
REQ-023 WRITE SHALL last exactly 1 cycle with w_valid=awvalid=1, waddr=WADDR_MAN, and wdata = HALTCn or NHALTCn selected by the held core and halt bit; next state is SETTLE.
REQ-024 SETTLE SHALL last exactly 1 cycle with all strobes low, allowing the manager's register to update; next state is READ.
REQ-025 READ SHALL hold arvalid=1 with raddr = held core index, zero-extended.
REQ-026 READ SHALL go to CHECK on rvalid=1, capturing rdata.
REQ-027 READ SHALL abort to error after TIMEOUT cycles without rvalid.
REQ-028 CHECK SHALL compare rdata[HALT_BIT] with the held halt bit.
REQ-029 On a CHECK match: pulse done, reset the retry count, return to IDLE.
REQ-030 On a CHECK mismatch: increment the retry count and return to WRITE if count < MAX_RETRY; otherwise go to error.
REQ-031 Error SHALL set err=1, load err_core with the held core, drop the command, and return to IDLE.
REQ-032 err SHALL clear only on rst.
REQ-033 pwr=0 in any non-IDLE state SHALL return the FSM to IDLE next cycle with strobes low, re-queue nothing, and raise no error.
REQ-034 A cmd_core >= NUM_CPUS SHALL be accepted but treated as an immediate error, with no bus traffic.
REQ-035 w_valid, awvalid and arvalid SHALL be registered outputs and never high simultaneously.

Reset
REQ-036 On rst: FIFO empty, FSM in IDLE, retry count 0.
REQ-037 On rst: w_valid, awvalid, arvalid, done, err, busy = 0; waddr, wdata, raddr, err_core = 0; cmd_ready = 1.
REQ-038 Reset mid-operation SHALL abandon the in-flight command with no further strobes.

Structure
REQ-039 NUM_CPUS, WADDR_MAN, HALTCn/NHALTCn codes and a new HALT_BIT constant SHALL come from package core_manage_types.
REQ-040 The FSM state enum SHALL be added to core_manage_types.
REQ-041 The queue SHALL be a sub-module, cmd_fifo (parameters WIDTH, DEPTH).

Verification
REQ-042 Push (core1, halt=0) with the manager model obeying -> one WRITE with wdata=NHALTC1, read raddr=1, done pulse 4 cycles after pop.
REQ-043 Model ignores the write for the core-2 halt -> exactly 3 WRITE cycles, then err=1, err_core=2.
REQ-044 Push 5 commands back-to-back with FIFO_DEPTH=4 while busy -> cmd_ready low after the 4th; all 5 complete in order.
REQ-045 Drop pwr during READ -> IDLE next cycle, arvalid=0, err stays 0; queued commands resume when pwr=1.
REQ-046 rvalid held low for 15 cycles -> err=1; assert rst mid-WRITE -> all outputs at reset values in the same cycle.
